// File: rtl/multiport_register_file.sv
// Register file with one write port, N registered read ports with write-to-read
// forwarding, and a hardware clear sweep that zeroes one register per cycle.
module multiport_register_file #(
    parameter int  DATA_WIDTH           = 8,
    parameter int  NUMBER_OF_REGISTERS  = 8,
    parameter int  NUMBER_OF_READ_PORTS = 2,
    localparam int ADDRESS_WIDTH        = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            enable,
    input  logic                                            write_enable,
    input  logic [ADDRESS_WIDTH-1:0]                        write_address,
    input  logic [DATA_WIDTH-1:0]                           write_data,
    input  logic [NUMBER_OF_READ_PORTS*ADDRESS_WIDTH-1:0]   read_address,
    output logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0]      read_data,
    output logic [NUMBER_OF_READ_PORTS-1:0]                 read_valid,
    input  logic                                            clear_start,
    output logic                                            busy
);
    localparam int AW  = ADDRESS_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int NRP = NUMBER_OF_READ_PORTS;
    localparam logic [AW:0]   REG_COUNT  = (AW+1)'(NUMBER_OF_REGISTERS);
    localparam logic [AW-1:0] LAST_INDEX = AW'(NUMBER_OF_REGISTERS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     sweep_index, sweep_index_next;
    logic [DW-1:0]     mem      [NUMBER_OF_REGISTERS];
    logic [DW-1:0]     mem_next [NUMBER_OF_REGISTERS];
    logic [NRP*DW-1:0] read_data_next;
    logic              write_commit;

    assign busy = (state == CLEAR);

    // mem_next is the array as it will be after this edge; reads use it for forwarding.
    always_comb begin
        state_next       = state;
        sweep_index_next = sweep_index;
        mem_next         = mem;
        write_commit     = enable && write_enable && (state == IDLE)
                           && ({1'b0, write_address} < REG_COUNT);
        if (write_commit) begin
            mem_next[write_address] = write_data;
        end
        case (state)
            IDLE: begin
                if (enable && clear_start) begin
                    state_next       = CLEAR;
                    sweep_index_next = '0;
                end
            end
            CLEAR: begin
                mem_next[sweep_index] = '0;
                if (sweep_index == LAST_INDEX) begin
                    state_next       = IDLE;
                    sweep_index_next = '0;
                end else begin
                    sweep_index_next = sweep_index + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_data_next = read_data;
        if (enable) begin
            for (int unsigned p = 0; p < NRP; p++) begin
                if ({1'b0, read_address[p*AW +: AW]} < REG_COUNT) begin
                    read_data_next[p*DW +: DW] = mem_next[read_address[p*AW +: AW]];
                end else begin
                    read_data_next[p*DW +: DW] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sweep_index <= '0;
            mem         <= '{default: '0};
            read_data   <= '0;
            read_valid  <= '0;
        end else begin
            state       <= state_next;
            sweep_index <= sweep_index_next;
            mem         <= mem_next;
            read_data   <= read_data_next;
            read_valid  <= {NRP{enable}};
        end
    end
endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: default 8x8/2-port instance plus a
// 6-register single-port instance for out-of-range address handling.
module tb_multiport_register_file;
    localparam int DW  = 8;
    localparam int NR  = 8;
    localparam int NRP = 2;
    localparam int AW  = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, enable, write_enable, clear_start, busy;
    logic [AW-1:0]     write_address;
    logic [DW-1:0]     write_data;
    logic [NRP*AW-1:0] read_address;
    logic [NRP*DW-1:0] read_data;
    logic [NRP-1:0]    read_valid;

    logic       s_enable, s_write_enable, s_clear_start, s_busy;
    logic [2:0] s_write_address, s_read_address;
    logic [7:0] s_write_data, s_read_data;
    logic [0:0] s_read_valid;

    multiport_register_file #(
        .DATA_WIDTH(DW), .NUMBER_OF_REGISTERS(NR), .NUMBER_OF_READ_PORTS(NRP)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data), .read_valid(read_valid),
        .clear_start(clear_start), .busy(busy)
    );

    multiport_register_file #(
        .DATA_WIDTH(8), .NUMBER_OF_REGISTERS(6), .NUMBER_OF_READ_PORTS(1)
    ) dut6 (
        .clock(clock), .reset(reset), .enable(s_enable), .write_enable(s_write_enable),
        .write_address(s_write_address), .write_data(s_write_data),
        .read_address(s_read_address), .read_data(s_read_data), .read_valid(s_read_valid),
        .clear_start(s_clear_start), .busy(s_busy)
    );

    typedef struct {
        int unsigned port;
        logic        valid;
        logic [7:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m[NR];
    logic [7:0]  hold[NRP];
    bit          m_clear;
    int unsigned m_idx;
    logic [7:0]  s_m[6];
    logic [7:0]  s_hold;
    int          busy_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m[i] = '0;
        for (int i = 0; i < 6; i++) s_m[i] = '0;
        for (int p = 0; p < NRP; p++) hold[p] = '0;
        s_hold  = '0;
        m_clear = 1'b0;
        m_idx   = 0;
    endtask

    // Drive one cycle on the main instance, predict its outputs, compare after the edge.
    task automatic cyc(input logic en, input logic we, input int wa, input logic [7:0] wd,
                       input int ra0, input int ra1, input logic cs);
        logic [7:0] nm[NR];
        exp_t e;
        enable        = en;
        write_enable  = we;
        write_address = 3'(wa);
        write_data    = wd;
        read_address  = {3'(ra1), 3'(ra0)};
        clear_start   = cs;
        nm = m;
        if (en && we && !m_clear) nm[wa] = wd;
        if (m_clear) nm[m_idx] = '0;
        for (int p = 0; p < NRP; p++) begin
            e.port = p;
            if (en) begin
                e.valid = 1'b1;
                e.data  = nm[(p == 0) ? ra0 : ra1];
                hold[p] = e.data;
            end else begin
                e.valid = 1'b0;
                e.data  = hold[p];
            end
            exp_q.push_back(e);
        end
        if (m_clear) begin
            if (m_idx == NR - 1) begin
                m_clear = 1'b0;
                m_idx   = 0;
            end else begin
                m_idx++;
            end
        end else if (en && cs) begin
            m_clear = 1'b1;
            m_idx   = 0;
        end
        m = nm;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("read_valid%0d", e.port), 32'(read_valid[e.port]), 32'(e.valid));
            check($sformatf("read_data%0d", e.port), 32'(read_data[e.port*DW +: DW]), 32'(e.data));
        end
        check("busy", 32'(busy), 32'(m_clear));
        if (busy) busy_count++;
    endtask

    task automatic cyc6(input logic en, input logic we, input int wa, input logic [7:0] wd,
                        input int ra);
        logic [7:0] nm[6];
        exp_t e;
        s_enable        = en;
        s_write_enable  = we;
        s_write_address = 3'(wa);
        s_write_data    = wd;
        s_read_address  = 3'(ra);
        s_clear_start   = 1'b0;
        nm = s_m;
        if (en && we && wa < 6) nm[wa] = wd;
        e.port = 0;
        if (en) begin
            e.valid = 1'b1;
            e.data  = (ra < 6) ? nm[ra] : 8'h00;
            s_hold  = e.data;
        end else begin
            e.valid = 1'b0;
            e.data  = s_hold;
        end
        exp_q.push_back(e);
        s_m = nm;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check($sformatf("n6_read_valid_a%0d", ra), 32'(s_read_valid), 32'(e.valid));
        check($sformatf("n6_read_data_a%0d", ra), 32'(s_read_data), 32'(e.data));
        check("n6_busy", 32'(s_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; write_enable = 1'b0; write_address = '0;
        write_data = '0; read_address = '0; clear_start = 1'b0;
        s_enable = 1'b0; s_write_enable = 1'b0; s_write_address = '0;
        s_write_data = '0; s_read_address = '0; s_clear_start = 1'b0;
        busy_count = 0;
        model_reset();
        #12;
        check("reset_read_data", 32'(read_data), 32'd0);
        check("reset_read_valid", 32'(read_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_n6_read_data", 32'(s_read_data), 32'd0);
        reset = 1'b0;

        cyc(1'b0, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        for (int a = 0; a < NR; a++) cyc(1'b1, 1'b0, 0, 8'h00, a, NR - 1 - a, 1'b0);

        cyc(1'b1, 1'b1, 3, 8'hA5, 0, 1, 1'b0);
        cyc(1'b1, 1'b0, 0, 8'h00, 3, 3, 1'b0);
        cyc(1'b1, 1'b1, 5, 8'h3C, 0, 5, 1'b0);
        cyc(1'b1, 1'b0, 0, 8'h00, 5, 3, 1'b0);

        // enable low: write ignored, read_data holds, read_valid drops
        cyc(1'b0, 1'b1, 2, 8'h99, 1, 1, 1'b0);
        cyc(1'b1, 1'b0, 0, 8'h00, 2, 2, 1'b0);

        for (int i = 0; i < NR; i++) cyc(1'b1, 1'b1, i, 8'(8'h10 + i), 7, i, 1'b0);
        busy_count = 0;
        cyc(1'b1, 1'b1, 2, 8'h55, 7, 2, 1'b1);
        for (int k = 0; k < NR; k++)
            cyc((k != 3), 1'b1, k, 8'hFF, 7, (k + 1) % NR, 1'b1);
        check("busy_cycles", 32'(busy_count), 32'(NR));
        for (int a = 0; a < NR; a++) cyc(1'b1, 1'b0, 0, 8'h00, a, NR - 1 - a, 1'b0);

        for (int i = 0; i < NR; i++) cyc(1'b1, 1'b1, i, 8'(8'h40 + i), i, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 8'h00, 7, 6, 1'b1);
        cyc(1'b1, 1'b0, 0, 8'h00, 7, 6, 1'b0);
        cyc(1'b1, 1'b0, 0, 8'h00, 7, 6, 1'b0);
        reset = 1'b1;
        #1;
        check("midsweep_reset_busy", 32'(busy), 32'd0);
        check("midsweep_reset_read_valid", 32'(read_valid), 32'd0);
        check("midsweep_reset_read_data", 32'(read_data), 32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        for (int a = 0; a < NR; a++) cyc(1'b1, 1'b0, 0, 8'h00, a, NR - 1 - a, 1'b0);
        busy_count = 0;
        cyc(1'b1, 1'b1, 4, 8'h77, 4, 0, 1'b1);
        for (int k = 0; k < NR + 1; k++) cyc(1'b1, 1'b0, 0, 8'h00, 4, k % NR, 1'b0);
        check("busy_cycles_after_reset", 32'(busy_count), 32'(NR));
        enable = 1'b0;

        for (int i = 0; i < 6; i++) cyc6(1'b1, 1'b1, i, 8'(8'h20 + i), i);
        cyc6(1'b1, 1'b1, 7, 8'hEE, 0);
        cyc6(1'b1, 1'b1, 6, 8'hDD, 5);
        for (int a = 0; a < 8; a++) cyc6(1'b1, 1'b0, 0, 8'h00, a);
        cyc6(1'b0, 1'b0, 0, 8'h00, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
